// File: rtl/mem_responder_pkg.sv
// Shared constants and widths for the mem_responder slice; the IO port is
// compiled in only when MEM_RESPONDER_IO_EN is defined.
package mem_responder_pkg;

    localparam int          AddrLen         = 32;
    localparam int          ByteLen         = 8;
    localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;
    localparam logic [7:0]  ZERO_BYTE       = 8'h00;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic        Enable          = 1'b1;
    localparam logic        Disable         = 1'b0;

    function automatic logic addr_hit(input logic [AddrLen-1:0] a, input logic [AddrLen-1:0] b);
        return ((a ^ b) == ZERO_WORD);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Byte-wide memory controller bus between a controller (master) and mem_responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [AddrLen-1:0] mem_a;
    logic [ByteLen-1:0] mem_dout;
    logic               mem_wr;
    logic [ByteLen-1:0] mem_din;
    logic               io_buffer_full;

    modport master (
        output mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );

endinterface

// File: rtl/mem_responder_byte_fifo.sv
// Power-of-two byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_r [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_ok_s  = en & pop & ~empty & ~rst;
    assign push_ok_s = en & push & (~full | pop_ok_s) & ~rst;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Data storage, not reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH because it is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-addressed RAM responder with one-cycle registered reads. Defining
// MEM_RESPONDER_IO_EN adds the IO data port at IO_ADDR (output FIFO + input strobe).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          RAM_ADDR_W = 17,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    mem_responder_if.slave bus,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic           io_overflow
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef MEM_RESPONDER_IO_EN
    localparam logic IO_EN = Enable;
`else
    localparam logic IO_EN = Disable;
`endif

    logic [7:0]            ram_r [0:(2**RAM_ADDR_W)-1];
    logic [RAM_ADDR_W-1:0] ram_idx_s;
    logic                  io_hit_s;
    logic                  ram_we_s;
    logic                  io_push_s;
    logic                  rx_take_s;
    logic [7:0]            mem_din_r;

    // Upper address bits alias onto the RAM; only an exact IO_ADDR match escapes.
    assign ram_idx_s = bus.mem_a[RAM_ADDR_W-1:0];
    assign io_hit_s  = IO_EN & addr_hit(bus.mem_a, IO_ADDR);

    // Side effects of the current bus cycle; reset and rdy=0 suppress all of them.
    always_comb begin
        ram_we_s  = Disable;
        io_push_s = Disable;
        rx_take_s = Disable;
        if (rst || !rdy) begin
            ram_we_s  = Disable;
            io_push_s = Disable;
            rx_take_s = Disable;
        end else if (bus.mem_wr) begin
            ram_we_s  = io_hit_s ? Disable : Enable;
            io_push_s = io_hit_s;
        end else begin
            rx_take_s = io_hit_s & rx_valid;
        end
    end

    // RAM array is kept out of reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= bus.mem_dout;
        end
    end

    // Registered read byte; writes return zero so the controller sees a clean bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din_r <= ZERO_BYTE;
        end else if (rdy) begin
            if (bus.mem_wr) begin
                mem_din_r <= ZERO_BYTE;
            end else if (io_hit_s) begin
                mem_din_r <= rx_valid ? rx_data : ZERO_BYTE;
            end else begin
                mem_din_r <= ram_r[ram_idx_s];
            end
        end
    end

    assign bus.mem_din = mem_din_r;
    assign rx_ready    = rx_take_s;

`ifdef MEM_RESPONDER_IO_EN
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             io_overflow_r;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (io_push_s),
        .pop   (tx_ready),
        .wdata (bus.mem_dout),
        .rdata (tx_data),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky drop flag: a full FIFO only loses a byte when nothing leaves on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_overflow_r <= Disable;
        end else if (io_push_s && fifo_full_s && !tx_ready) begin
            io_overflow_r <= Enable;
        end
    end

    // Two-entry margin covers the write already in flight behind the registered response.
    assign bus.io_buffer_full = (fifo_count_s >= CNT_W'(FIFO_DEPTH - 2));
    assign tx_valid           = ~fifo_empty_s;
    assign io_overflow        = io_overflow_r;
`else
    logic unused_s;

    assign unused_s           = ^{tx_ready, io_push_s, bus.mem_a};
    assign tx_data            = ZERO_BYTE;
    assign tx_valid           = Disable;
    assign bus.io_buffer_full = Disable;
    assign io_overflow        = Disable;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized RAM/IO traffic against a
// queue/associative-array model; IO scenarios follow MEM_RESPONDER_IO_EN.
module tb_mem_responder;

    localparam int          RAM_ADDR_W = 17;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] IO_ADDR    = 32'h0003_0000;
    localparam logic [31:0] IDX_MASK   = (32'h1 << RAM_ADDR_W) - 32'h1;
`ifdef MEM_RESPONDER_IO_EN
    localparam bit IO_ON = 1'b1;
`else
    localparam bit IO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       io_overflow;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] ram_model [int];
    logic [7:0] exp_din;
`ifdef MEM_RESPONDER_IO_EN
    logic [7:0] fifo_model [$];
    logic       overflow_model;
`endif

    mem_responder_if bus ();

    mem_responder #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IO_ADDR    (IO_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bus         (bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .io_overflow (io_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return IO_ON && (a == IO_ADDR);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        rst = 1'b0;
`ifdef MEM_RESPONDER_IO_EN
        fifo_model.delete();
        overflow_model = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
        drive(IO_ADDR, 1'b0, 8'h00);
        #1;
        checks++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); else passes++;
        step();
        checks++; if (bus.mem_din !== 8'h00) $display("FAIL reset_mem_din: got %h expected 00", bus.mem_din); else passes++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else passes++;
        checks++; if (bus.io_buffer_full !== 1'b0) $display("FAIL reset_buf_full: got %b expected 0", bus.io_buffer_full); else passes++;
        checks++; if (io_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", io_overflow); else passes++;
        rst = 1'b0; rx_valid = 1'b0;
`ifdef MEM_RESPONDER_IO_EN
        fifo_model.delete();
        overflow_model = 1'b0;
`endif
    endtask

    task automatic test_write_read();
        drive(32'h0000_0010, 1'b1, 8'hA5);
        step();
        ram_model[32'h10] = 8'hA5;
        checks++; if (bus.mem_din !== 8'h00) $display("FAIL wr_din_zero: got %h expected 00", bus.mem_din); else passes++;
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        checks++; if (bus.mem_din !== 8'hA5) $display("FAIL wr_rd: got %h expected a5", bus.mem_din); else passes++;
    endtask

    task automatic test_burst_read();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            drive(32'h0000_0100 + 32'(i), 1'b1, b);
            step();
            ram_model[32'h100 + i] = b;
        end
        for (int i = 3; i >= 0; i--) begin
            drive(32'h0000_0100 + 32'(i), 1'b0, 8'h00);
            step();
            checks++; if (bus.mem_din !== ram_model[32'h100 + i]) $display("FAIL burst_rd[%0d]: got %h expected %h", i, bus.mem_din, ram_model[32'h100 + i]); else passes++;
        end
    endtask

    task automatic test_random_ram();
        int         written [$];
        logic [31:0] a;
        logic [7:0]  d;
        int          idx;
        bit          r_rdy;
        written = '{32'h10, 32'h100, 32'h101, 32'h102, 32'h103};
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        exp_din = ram_model[32'h10];
        for (int i = 0; i < 60; i++) begin
            r_rdy = ($urandom_range(0, 4) != 0);
            rdy = r_rdy;
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom;
                if (is_io(a)) a = a ^ 32'h8000_0000;
                d = 8'($urandom);
                drive(a, 1'b1, d);
                step();
                if (r_rdy) begin
                    ram_model[int'(a & IDX_MASK)] = d;
                    written.push_back(int'(a & IDX_MASK));
                    exp_din = 8'h00;
                end
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                a = ($urandom & ~IDX_MASK) | 32'(idx);
                if (is_io(a)) a = a ^ 32'h8000_0000;
                drive(a, 1'b0, 8'h00);
                step();
                if (r_rdy) exp_din = ram_model[idx];
            end
            checks++; if (bus.mem_din !== exp_din) $display("FAIL rand_ram[%0d]: got %h expected %h addr %h", i, bus.mem_din, exp_din, a); else passes++;
        end
        rdy = 1'b1;
    endtask

    task automatic test_rdy_freeze_ram();
        drive(32'h0000_2000, 1'b1, 8'h55);
        step();
        drive(32'h0000_2000, 1'b0, 8'h00);
        step();
        rdy = 1'b0;
        drive(32'h0000_2000, 1'b1, 8'hAA);
        step();
        checks++; if (bus.mem_din !== 8'h55) $display("FAIL freeze_din_hold: got %h expected 55", bus.mem_din); else passes++;
        rdy = 1'b1;
        drive(32'h0000_2000, 1'b0, 8'h00);
        step();
        checks++; if (bus.mem_din !== 8'h55) $display("FAIL freeze_ram: got %h expected 55", bus.mem_din); else passes++;
    endtask

    task automatic test_reset_mid_read();
        rst = 1'b1;
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        rst = 1'b0;
        checks++; if (bus.mem_din !== 8'h00) $display("FAIL reset_mid_read: got %h expected 00", bus.mem_din); else passes++;
    endtask

`ifdef MEM_RESPONDER_IO_EN
    task automatic io_cycle(input logic wr_io, input logic [7:0] d, input logic trdy, input logic r_rdy);
        logic [7:0] tmp;
        bit         pop;
        rdy = r_rdy; tx_ready = trdy;
        if (wr_io) drive(IO_ADDR, 1'b1, d);
        else drive(32'h0000_0010, 1'b0, 8'h00);
        pop = r_rdy && trdy && (fifo_model.size() > 0);
        step();
        if (pop) tmp = fifo_model.pop_front();
        if (r_rdy && wr_io) begin
            if (fifo_model.size() < FIFO_DEPTH) fifo_model.push_back(d);
            else overflow_model = 1'b1;
        end
        rdy = 1'b1; tx_ready = 1'b0;
    endtask

    task automatic test_io_fill_overflow();
        logic exp_full;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            io_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
            exp_full = (fifo_model.size() >= FIFO_DEPTH - 2);
            checks++; if (bus.io_buffer_full !== exp_full) $display("FAIL fill_buf_full[%0d]: got %b expected %b", i, bus.io_buffer_full, exp_full); else passes++;
            checks++; if (io_overflow !== overflow_model) $display("FAIL fill_overflow[%0d]: got %b expected %b", i, io_overflow, overflow_model); else passes++;
        end
        checks++; if (io_overflow !== 1'b1) $display("FAIL ninth_overflow: got %b expected 1", io_overflow); else passes++;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checks++; if (tx_data !== fifo_model[0]) $display("FAIL fill_order[%0d]: got %h expected %h", i, tx_data, fifo_model[0]); else passes++;
            io_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        end
        checks++; if (tx_valid !== 1'b0) $display("FAIL fill_drained: got %b expected 0", tx_valid); else passes++;
    endtask

    task automatic test_io_full_push_pop();
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) io_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        io_cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
        checks++; if (io_overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", io_overflow); else passes++;
        checks++; if (bus.io_buffer_full !== 1'b1) $display("FAIL pp_buf_full: got %b expected 1", bus.io_buffer_full); else passes++;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checks++; if (tx_data !== fifo_model[0]) $display("FAIL pp_order[%0d]: got %h expected %h", i, tx_data, fifo_model[0]); else passes++;
            io_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        end
        checks++; if (tx_valid !== 1'b0) $display("FAIL pp_drained: got %b expected 0", tx_valid); else passes++;
    endtask

    task automatic test_io_random();
        logic exp_full;
        logic exp_valid;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            io_cycle(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) != 0));
            exp_valid = (fifo_model.size() > 0);
            exp_full  = (fifo_model.size() >= FIFO_DEPTH - 2);
            checks++; if (tx_valid !== exp_valid) $display("FAIL rand_tx_valid[%0d]: got %b expected %b", i, tx_valid, exp_valid); else passes++;
            if (exp_valid) begin
                checks++; if (tx_data !== fifo_model[0]) $display("FAIL rand_tx_data[%0d]: got %h expected %h", i, tx_data, fifo_model[0]); else passes++;
            end
            checks++; if (bus.io_buffer_full !== exp_full) $display("FAIL rand_buf_full[%0d]: got %b expected %b", i, bus.io_buffer_full, exp_full); else passes++;
            checks++; if (io_overflow !== overflow_model) $display("FAIL rand_overflow[%0d]: got %b expected %b", i, io_overflow, overflow_model); else passes++;
        end
    endtask

    task automatic test_io_read();
        logic [7:0] r;
        rx_valid = 1'b1; rx_data = 8'h41;
        drive(IO_ADDR, 1'b0, 8'h00);
        #1;
        checks++; if (rx_ready !== 1'b1) $display("FAIL io_rd_strobe: got %b expected 1", rx_ready); else passes++;
        step();
        checks++; if (bus.mem_din !== 8'h41) $display("FAIL io_rd_data: got %h expected 41", bus.mem_din); else passes++;
        rx_valid = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b0) $display("FAIL io_rd_no_strobe: got %b expected 0", rx_ready); else passes++;
        step();
        checks++; if (bus.mem_din !== 8'h00) $display("FAIL io_rd_empty: got %h expected 00", bus.mem_din); else passes++;
        r = 8'($urandom) | 8'h01;
        rx_valid = 1'b1; rx_data = r; rdy = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b0) $display("FAIL io_rd_rdy0_strobe: got %b expected 0", rx_ready); else passes++;
        step();
        checks++; if (bus.mem_din !== 8'h00) $display("FAIL io_rd_rdy0_hold: got %h expected 00", bus.mem_din); else passes++;
        rdy = 1'b1;
        drive(32'h0000_0010, 1'b0, 8'h00);
        #1;
        checks++; if (rx_ready !== 1'b0) $display("FAIL io_rd_ram_strobe: got %b expected 0", rx_ready); else passes++;
        drive(IO_ADDR, 1'b0, 8'h00);
        step();
        checks++; if (bus.mem_din !== r) $display("FAIL io_rd_rand: got %h expected %h", bus.mem_din, r); else passes++;
        rx_valid = 1'b0;
    endtask

    task automatic test_io_rdy_and_reset();
        do_reset();
        io_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++; if (tx_valid !== 1'b0) $display("FAIL rdy0_push: got %b expected 0", tx_valid); else passes++;
        for (int i = 0; i < 3; i++) io_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        io_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (tx_valid !== 1'b1) $display("FAIL drain_valid: got %b expected 1", tx_valid); else passes++;
        rst = 1'b1; tx_ready = 1'b1;
        step();
        rst = 1'b0; tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_mid_drain: got %b expected 0", tx_valid); else passes++;
        checks++; if (bus.io_buffer_full !== 1'b0) $display("FAIL reset_mid_full: got %b expected 0", bus.io_buffer_full); else passes++;
        fifo_model.delete();
        overflow_model = 1'b0;
    endtask
`else
    task automatic test_io_disabled();
        logic [7:0] d;
        rx_valid = 1'b1; rx_data = 8'h41; tx_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            d = 8'($urandom);
            drive(IO_ADDR, 1'b1, d);
            #1;
            checks++; if (rx_ready !== 1'b0) $display("FAIL dis_rx_ready[%0d]: got %b expected 0", i, rx_ready); else passes++;
            step();
            ram_model[int'(IO_ADDR & IDX_MASK)] = d;
        end
        checks++; if (tx_valid !== 1'b0) $display("FAIL dis_tx_valid: got %b expected 0", tx_valid); else passes++;
        checks++; if (bus.io_buffer_full !== 1'b0) $display("FAIL dis_buf_full: got %b expected 0", bus.io_buffer_full); else passes++;
        checks++; if (io_overflow !== 1'b0) $display("FAIL dis_overflow: got %b expected 0", io_overflow); else passes++;
        drive(IO_ADDR, 1'b0, 8'h00);
        step();
        checks++; if (bus.mem_din !== ram_model[int'(IO_ADDR & IDX_MASK)]) $display("FAIL dis_io_as_ram: got %h expected %h", bus.mem_din, ram_model[int'(IO_ADDR & IDX_MASK)]); else passes++;
        drive(IO_ADDR ^ 32'h4000_0000, 1'b0, 8'h00);
        step();
        checks++; if (bus.mem_din !== ram_model[int'(IO_ADDR & IDX_MASK)]) $display("FAIL dis_alias: got %h expected %h", bus.mem_din, ram_model[int'(IO_ADDR & IDX_MASK)]); else passes++;
        rx_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_burst_read();
        test_random_ram();
        test_rdy_freeze_ram();
        test_reset_mid_read();
`ifdef MEM_RESPONDER_IO_EN
        test_io_fill_overflow();
        test_io_full_push_pop();
        test_io_random();
        test_io_read();
        test_io_rdy_and_reset();
`else
        test_io_disabled();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
